// File: rtl/approx_cla_adder_pipe.sv
// approx_cla_adder_pipe
//   Pipelined carry-lookahead adder whose low L bits use an XNOR
//   approximate sum cell (L chosen per transaction). The exact sum is built
//   from the same carry chain, so every result comes with its error distance.
//   A saturating counter tracks how many delivered results were inexact.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   in_valid_i / in_ready_o  operand handshake (add1_i, add2_i, approx_bits_i)
//   out_valid_o / out_ready_i result handshake
//   result_o                 approximate {carry_out, sum}
//   exact_o                  exact add1 + add2
//   err_o, err_flag_o        |result_o - exact_o| and err_o != 0
//   clear_i                  synchronous clear of err_count_o
//   err_count_o              saturating count of delivered inexact results
module approx_cla_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int AW     = $clog2(WIDTH + 1),
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic [AW-1:0]    approx_bits_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   result_o,
  output logic [WIDTH:0]   exact_o,
  output logic [WIDTH:0]   err_o,
  output logic             err_flag_o,
  input  logic             clear_i,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int SL = WIDTH / STAGES;

  generate
    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("approx_cla_adder_pipe: WIDTH must be >= 2 and a multiple of STAGES");
    end
  endgenerate

  function automatic logic [AW-1:0] clamp_l(input logic [AW-1:0] n);
    return (n > AW'(WIDTH)) ? AW'(WIDTH) : n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic stall;
  assign stall      = out_valid_o & ~out_ready_i;
  assign in_ready_o = ~stall;

  // Stage s register holds the operands plus sums/carry after slice s.
  logic             vld_p   [STAGES];
  logic             carry_p [STAGES];
  logic [AW-1:0]    l_p     [STAGES];
  logic [WIDTH-1:0] a_p     [STAGES];
  logic [WIDTH-1:0] b_p     [STAGES];
  logic [WIDTH-1:0] sap_p   [STAGES];
  logic [WIDTH-1:0] sex_p   [STAGES];

  // Inputs of each slice: raw operands for slice 0, previous stage otherwise.
  logic             src_c   [STAGES];
  logic [AW-1:0]    src_l   [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [WIDTH-1:0] src_sap [STAGES];
  logic [WIDTH-1:0] src_sex [STAGES];

  logic             carry_n [STAGES];
  logic [WIDTH-1:0] sap_n   [STAGES];
  logic [WIDTH-1:0] sex_n   [STAGES];

  always_comb begin
    src_c[0]   = 1'b0;
    src_l[0]   = clamp_l(approx_bits_i);
    src_a[0]   = add1_i;
    src_b[0]   = add2_i;
    src_sap[0] = '0;
    src_sex[0] = '0;
    for (int s = 1; s < STAGES; s++) begin
      src_c[s]   = carry_p[s-1];
      src_l[s]   = l_p[s-1];
      src_a[s]   = a_p[s-1];
      src_b[s]   = b_p[s-1];
      src_sap[s] = sap_p[s-1];
      src_sex[s] = sex_p[s-1];
    end
  end

  // Slice logic: the carry is always exact; only the sum bit below L is
  // replaced by the XNOR cell, so approximate and exact share carries.
  always_comb begin
    logic             c;
    logic [WIDTH-1:0] sap;
    logic [WIDTH-1:0] sex;
    c   = 1'b0;
    sap = '0;
    sex = '0;
    for (int s = 0; s < STAGES; s++) begin
      c   = src_c[s];
      sap = src_sap[s];
      sex = src_sex[s];
      for (int j = 0; j < SL; j++) begin
        sex[s*SL+j] = src_a[s][s*SL+j] ^ src_b[s][s*SL+j] ^ c;
        sap[s*SL+j] = ((s*SL+j) < int'(src_l[s])) ?
                      ~(src_a[s][s*SL+j] ^ src_b[s][s*SL+j]) : sex[s*SL+j];
        c = (src_a[s][s*SL+j] & src_b[s][s*SL+j]) |
            ((src_a[s][s*SL+j] | src_b[s][s*SL+j]) & c);
      end
      carry_n[s] = c;
      sap_n[s]   = sap;
      sex_n[s]   = sex;
    end
  end

  logic [WIDTH:0] fin_ap;
  logic [WIDTH:0] fin_ex;
  logic [WIDTH:0] fin_err;
  assign fin_ap  = {carry_p[STAGES-1], sap_p[STAGES-1]};
  assign fin_ex  = {carry_p[STAGES-1], sex_p[STAGES-1]};
  assign fin_err = (fin_ap >= fin_ex) ? (fin_ap - fin_ex) : (fin_ex - fin_ap);

  // ---- carry stages 0..STAGES-1: control ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < STAGES; s++) vld_p[s] <= 1'b0;
    end else if (!stall) begin
      vld_p[0] <= in_valid_i;
      for (int s = 1; s < STAGES; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  // ---- carry stages 0..STAGES-1: data ----
  always_ff @(posedge clk_i) begin
    if (!stall) begin
      for (int s = 0; s < STAGES; s++) begin
        carry_p[s] <= carry_n[s];
        l_p[s]     <= src_l[s];
        a_p[s]     <= src_a[s];
        b_p[s]     <= src_b[s];
        sap_p[s]   <= sap_n[s];
        sex_p[s]   <= sex_n[s];
      end
    end
  end

  // ---- output stage: error distance; data only loads on a valid result so
  // the outputs keep the last delivered value between transactions ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      result_o    <= '0;
      exact_o     <= '0;
      err_o       <= '0;
      err_flag_o  <= 1'b0;
    end else if (!stall) begin
      out_valid_o <= vld_p[STAGES-1];
      if (vld_p[STAGES-1]) begin
        result_o   <= fin_ap;
        exact_o    <= fin_ex;
        err_o      <= fin_err;
        err_flag_o <= |fin_err;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_count_o <= '0;
    end else if (clear_i) begin
      err_count_o <= '0;
    end else if (out_valid_o && out_ready_i && err_flag_o) begin
      err_count_o <= sat_inc(err_count_o);
    end
  end

endmodule

// File: tb/tb_approx_cla_adder_pipe.sv
module tb_approx_cla_adder_pipe;

  localparam int W  = 32;
  localparam int S  = 4;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  add1;
  logic [W-1:0]  add2;
  logic [AW-1:0] abits;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    result;
  logic [W:0]    exact;
  logic [W:0]    err;
  logic          err_flag;
  logic          clear;
  logic [15:0]   err_count;

  logic          d2_in_ready;
  logic          d2_out_valid;
  logic [W:0]    d2_result;
  logic [W:0]    d2_exact;
  logic [W:0]    d2_err;
  logic          d2_err_flag;
  logic [1:0]    d2_err_count;

  always #5 clk = ~clk;

  approx_cla_adder_pipe #(.WIDTH(W), .STAGES(S), .AW(AW), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .add1_i(add1), .add2_i(add2), .approx_bits_i(abits),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .exact_o(exact), .err_o(err), .err_flag_o(err_flag),
    .clear_i(clear), .err_count_o(err_count)
  );

  approx_cla_adder_pipe #(.WIDTH(W), .STAGES(S), .AW(AW), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(d2_in_ready),
    .add1_i(add1), .add2_i(add2), .approx_bits_i(abits),
    .out_valid_o(d2_out_valid), .out_ready_i(out_ready),
    .result_o(d2_result), .exact_o(d2_exact), .err_o(d2_err), .err_flag_o(d2_err_flag),
    .clear_i(clear), .err_count_o(d2_err_count)
  );

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [AW-1:0] l;
    logic [W:0]    res;
    logic [W:0]    ex;
    logic [W:0]    err;
    logic          flag;
  } vec_t;

  vec_t tv[12];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_c16 = 0;
  int   exp_c2  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic count_dlv(input logic flag, input bit clr);
    if (clr) begin
      exp_c16 = 0;
      exp_c2  = 0;
    end else if (flag) begin
      if (exp_c16 < 65535) exp_c16++;
      if (exp_c2 < 3) exp_c2++;
    end
  endtask

  task automatic check_out(input string tag, input int k);
    chk({tag, "_result"}, 64'(result), 64'(tv[k].res));
    chk({tag, "_exact"}, 64'(exact), 64'(tv[k].ex));
    chk({tag, "_err"}, 64'(err), 64'(tv[k].err));
    chk({tag, "_flag"}, 64'(err_flag), 64'(tv[k].flag));
  endtask

  // Single transaction from a negedge: latency, values, delivery, hold, counters.
  task automatic run_vec(input int k, input bit clr);
    int cyc;
    add1 = tv[k].a; add2 = tv[k].b; abits = tv[k].l;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); cyc = 1;
    @(negedge clk); in_valid = 1'b0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    chk($sformatf("latency_v%0d", k), 64'(cyc), 64'(S + 1));
    check_out($sformatf("v%0d", k), k);
    clear = clr;
    @(posedge clk);
    count_dlv(tv[k].flag, clr);
    @(negedge clk);
    clear = 1'b0;
    chk($sformatf("valid_drop_v%0d", k), 64'(out_valid), 64'(0));
    chk($sformatf("hold_v%0d", k), 64'(result), 64'(tv[k].res));
    chk($sformatf("err_count_v%0d", k), 64'(err_count), 64'(exp_c16));
    chk($sformatf("err_count_w2_v%0d", k), 64'(d2_err_count), 64'(exp_c2));
  endtask

  initial begin
    int tx, rx, seen;
    bit acc, dlv;

    //        a             b             l   res              ex               err             flag
    tv[0]  = '{32'hFFFFFFFF, 32'h00000001, 0,  33'h100000000, 33'h100000000, 33'h0,         1'b0};
    tv[1]  = '{32'h00000001, 32'h00000002, 8,  33'h0000000FC, 33'h000000003, 33'hF9,        1'b1};
    tv[2]  = '{32'h00000000, 32'h00000000, 40, 33'h0FFFFFFFF, 33'h000000000, 33'hFFFFFFFF,  1'b1};
    tv[3]  = '{32'h0000000F, 32'h00000001, 4,  33'h000000011, 33'h000000010, 33'h1,         1'b1};
    tv[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32, 33'h1FFFFFFFF, 33'h1FFFFFFFE, 33'h1,         1'b1};
    tv[5]  = '{32'h12345678, 32'h0000A988, 16, 33'h01235000F, 33'h012350000, 33'hF,         1'b1};
    tv[6]  = '{32'h80000000, 32'h80000000, 0,  33'h100000000, 33'h100000000, 33'h0,         1'b0};
    tv[7]  = '{32'h00000000, 32'h00000001, 1,  33'h000000000, 33'h000000001, 33'h1,         1'b1};
    tv[8]  = '{32'h00000005, 32'h00000002, 3,  33'h000000000, 33'h000000007, 33'h7,         1'b1};
    tv[9]  = '{32'hAAAAAAAA, 32'h55555555, 2,  33'h0FFFFFFFC, 33'h0FFFFFFFF, 33'h3,         1'b1};
    tv[10] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 32, 33'h000000000, 33'h0FFFFFFFF, 33'hFFFFFFFF,  1'b1};
    tv[11] = '{32'h000000FF, 32'h000000FF, 8,  33'h0000001FF, 33'h0000001FE, 33'h1,         1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
    add1 = '0; add2 = '0; abits = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_exact", 64'(exact), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_flag", 64'(err_flag), 64'(0));
    chk("rst_count", 64'(err_count), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 12; k++) run_vec(k, 1'b0);

    // Back-to-back stream of tv[3..10] with out_ready low for 3 cycles.
    tx = 0; rx = 0;
    for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
      out_ready = !(cyc >= 7 && cyc <= 9);
      in_valid  = (tx < 8);
      if (tx < 8) begin
        add1 = tv[3+tx].a; add2 = tv[3+tx].b; abits = tv[3+tx].l;
      end
      #1;
      if (!out_ready) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_in_ready", 64'(in_ready), 64'(0));
        if (rx < 8) chk("stall_hold", 64'(result), 64'(tv[3+rx].res));
      end
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (dlv && rx < 8) check_out($sformatf("stream%0d", rx), 3 + rx);
      @(posedge clk);
      if (acc) tx++;
      if (dlv && rx < 8) begin
        count_dlv(tv[3+rx].flag, 1'b0);
        rx++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_delivered", 64'(rx), 64'(8));
    chk("stream_err_count", 64'(err_count), 64'(exp_c16));

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) begin
      add1 = tv[i].a; add2 = tv[i].b; abits = tv[i].l; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_c16 = 0; exp_c2 = 0;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_result", 64'(result), 64'(0));
    chk("midrst_exact", 64'(exact), 64'(0));
    chk("midrst_err", 64'(err), 64'(0));
    chk("midrst_flag", 64'(err_flag), 64'(0));
    chk("midrst_count", 64'(err_count), 64'(0));
    chk("midrst_count_w2", 64'(d2_err_count), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("no_ghost_after_reset", 64'(seen), 64'(0));
    @(negedge clk);
    run_vec(2, 1'b0);

    // Counter clear, saturation of the 2-bit counter, clear on a delivery edge.
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    exp_c16 = 0; exp_c2 = 0;
    chk("clear_count", 64'(err_count), 64'(0));
    chk("clear_count_w2", 64'(d2_err_count), 64'(0));
    run_vec(1, 1'b0);
    run_vec(3, 1'b0);
    run_vec(5, 1'b0);
    run_vec(7, 1'b0);
    run_vec(8, 1'b0);
    chk("sat_count_w2", 64'(d2_err_count), 64'(3));
    chk("unsat_count", 64'(err_count), 64'(5));
    run_vec(11, 1'b1);
    chk("clear_on_dlv", 64'(err_count), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
